// File: rtl/la_capture_ctrl.sv
// Logic-analyser capture controller: arms the trigger stage, decimates the sample
// stream and records pre/post-trigger samples into SRAM as a circular buffer.
module la_capture_ctrl #(
  parameter int ADDR_W = 19,
  parameter int DEC_W  = 16
) (
  input  logic              clock,
  input  logic              RST,
  input  logic              START,
  input  logic              STOP,
  input  logic [DEC_W-1:0]  DECIM,
  input  logic [ADDR_W-1:0] PRE_CNT,
  input  logic [ADDR_W-1:0] POST_CNT,
  input  logic [7:0]        DATA_IN,
  input  logic              trig_in,
  output logic              trig_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_we_n,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WAIT_TRIG,
    S_POST,
    S_DONE
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   cnt;
  logic [DEC_W-1:0]    dec_cnt;

  logic                tick;
  logic                write_now;
  logic [ADDR_W-1:0]   cnt_inc;
  logic [ADDR_W-1:0]   wr_ptr_inc;

  assign tick       = (dec_cnt == '0);
  // POST_CNT=0 finishes on the first POST cycle without recording anything.
  assign write_now  = tick && !(state == S_POST && POST_CNT == '0);
  assign cnt_inc    = cnt + ADDR_W'(tick);
  assign wr_ptr_inc = wr_ptr + ADDR_W'(1);

  always_ff @(posedge clock) begin
    if (!RST) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      cnt       <= '0;
      dec_cnt   <= '0;
      mem_addr  <= '0;
      mem_data  <= '0;
      mem_we_n  <= 1'b1;
      trig_en   <= 1'b0;
      trig_addr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      mem_we_n <= 1'b1;
      case (state)
        S_IDLE, S_DONE: begin
          if (!STOP && START) begin
            state   <= S_PRE;
            wr_ptr  <= '0;
            cnt     <= '0;
            dec_cnt <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        default: begin
          if (STOP) begin
            state   <= S_IDLE;
            trig_en <= 1'b0;
            busy    <= 1'b0;
          end else begin
            dec_cnt <= tick ? DECIM : dec_cnt - DEC_W'(1);
            if (write_now) begin
              mem_data <= DATA_IN;
              mem_addr <= wr_ptr;
              mem_we_n <= 1'b0;
              wr_ptr   <= wr_ptr_inc;
            end
            case (state)
              S_PRE: begin
                cnt <= cnt_inc;
                if (PRE_CNT == '0 || cnt_inc == PRE_CNT) begin
                  state   <= S_WAIT_TRIG;
                  trig_en <= 1'b1;
                end
              end
              S_WAIT_TRIG: begin
                // trig_addr points at the first sample written after the trigger.
                if (trig_en && !trig_in) begin
                  trig_addr <= write_now ? wr_ptr_inc : wr_ptr;
                  trig_en   <= 1'b0;
                  cnt       <= '0;
                  state     <= S_POST;
                end
              end
              S_POST: begin
                if (POST_CNT == '0) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end else begin
                  cnt <= cnt_inc;
                  if (cnt_inc == POST_CNT) begin
                    state <= S_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                  end
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: doc/la_capture_ctrl.md
# la_capture_ctrl

Capture controller that sits directly downstream of the logic-analyser trigger stage. It arms the trigger, decimates the 8-bit sample stream, and writes samples into external SRAM as a circular buffer. It guarantees a programmed number of pre-trigger samples, then records a programmed number of post-trigger samples. It reports the buffer address at which the trigger occurred.

## Interface
Parameters:
- ADDR_W, 19, SRAM address width; the write pointer wraps modulo 2^ADDR_W
- DEC_W, 16, decimation counter width

Ports:
- clock  in  1  system clock; all logic on rising edge
- RST  in  1  synchronous reset, active-low
- START  in  1  arm request, level sampled each clock
- STOP  in  1  abort request, level sampled each clock
- DECIM  in  DEC_W  one sample per DECIM+1 clocks
- PRE_CNT  in  ADDR_W  pre-trigger samples required before arming
- POST_CNT  in  ADDR_W  samples recorded after trigger
- DATA_IN  in  8  logic-analyser sample bus
- trig_in  in  1  trigger from trigger stage, active-low level
- trig_en  out  1  enable to trigger stage
- mem_addr  out  ADDR_W  SRAM write address
- mem_data  out  8  SRAM write data
- mem_we_n  out  1  SRAM write strobe, active-low, one clock per sample
- trig_addr  out  ADDR_W  address of first post-trigger sample
- busy  out  1  capture in progress
- done  out  1  capture complete

## Operation
- States: IDLE, PRE, WAIT_TRIG, POST, DONE.
- Reset (RST=0 at a clock edge): state=IDLE, wr_ptr=0, mem_addr=0, mem_data=0, mem_we_n=1, trig_en=0, trig_addr=0, busy=0, done=0. Reset mid-capture aborts immediately.
- Sample tick: decimation counter is loaded with 0 on entry to PRE, so a tick occurs in the first PRE cycle. The counter is then reloaded with DECIM after each tick and decrements otherwise. A tick occurs when the counter is 0. DECIM=0 gives a tick every clock.
- On every tick in PRE, WAIT_TRIG or POST: mem_data<=DATA_IN, mem_addr<=wr_ptr, mem_we_n<=0, and wr_ptr<=wr_ptr+1 (wraps at 2^ADDR_W). On non-tick cycles mem_we_n<=1. In IDLE and DONE, mem_we_n=1.
- IDLE: busy=0. START=1 -> PRE: wr_ptr cleared, sample count cleared, busy<=1, done<=0.
- PRE: sample count increments per tick. When count equals PRE_CNT -> WAIT_TRIG and trig_en<=1. PRE_CNT=0 moves to WAIT_TRIG on the first PRE cycle, and that cycle still writes its tick.
- WAIT_TRIG: sampling continues, overwriting circularly. trig_in is qualified only when the registered trig_en is 1. On trig_in=0: trig_addr<=wr_ptr after any tick in this cycle (the next address to be written), trig_en<=0, post count cleared, -> POST.
- POST: post count increments per tick. When count equals POST_CNT -> DONE. POST_CNT=0 enters DONE the cycle after the trigger, with no post samples.
- DONE: busy=0, done=1, trig_en=0. Held until START=1, which re-arms to PRE and clears done.
- STOP=1 in PRE, WAIT_TRIG or POST -> IDLE: trig_en<=0, busy<=0, done stays 0, mem_we_n<=1 next cycle.
- Priority within one cycle: RST > STOP > trigger/count completion > START. START is ignored while busy.

## Timing
- DATA_IN sampled at a tick edge appears on mem_data/mem_addr with mem_we_n=0 for exactly one clock after that edge.
- trig_en rises one clock after the final pre-trigger tick. A trig_in low in that same cycle is ignored.
- trig_in to trig_en falling: 1 clock. trig_addr is valid from the clock after the trigger and is stable until the next START.
- done rises one clock after the last post-trigger write edge.

## Test plan
- DECIM=0, PRE_CNT=4, POST_CNT=3, START pulse, trig_in low 10 clocks later -> mem_we_n low every clock; trig_en rises after 4 writes; trig_addr equals the write count at the trigger; exactly 3 writes after the trigger; done=1.
- DECIM=2, PRE_CNT=2, POST_CNT=2 -> mem_we_n pulses every 3rd clock; addresses 0,1,2,... are consecutive.
- ADDR_W=4, PRE_CNT=2, trigger delayed 20 ticks -> mem_addr wraps 15->0; trig_addr=(20+2) mod 16=6, post writes continue at 6,7.
- trig_in held low before and during the arming cycle -> no trigger until the cycle after trig_en=1; no writes lost.
- STOP asserted during POST -> IDLE next clock; done=0; mem_we_n=1. A following START re-arms with wr_ptr=0.
- RST=0 in WAIT_TRIG -> all outputs at reset values after one clock; START and trig_in are ignored while RST=0.
